// File: rtl/pcm_access_sched_if.sv
// PCM array port: the access scheduler is the master, the array is the slave.
// The array raises pcm_gnt to accept a request; read data follows RD_LAT cycles later.
interface pcm_access_sched_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              pcm_req;
  logic              pcm_we;
  logic [ADDR_W-1:0] pcm_addr;
  logic [DATA_W-1:0] pcm_wdata;
  logic              pcm_gnt;
  logic [DATA_W-1:0] pcm_rdata;

  modport master (
    output pcm_req, pcm_we, pcm_addr, pcm_wdata,
    input  pcm_gnt, pcm_rdata
  );

  modport slave (
    input  pcm_req, pcm_we, pcm_addr, pcm_wdata,
    output pcm_gnt, pcm_rdata
  );
endinterface

// File: rtl/pcm_access_sched.sv
// Runs one scheduled access on the PCM array port. Writes are program,
// read back, compare, and are retried up to MAX_RETRY extra times on mismatch.
module pcm_access_sched #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 12,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              schedule,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_in,
  output logic              resolved,
  output logic [DATA_W-1:0] data_in,
  output logic              wr_err,
  output logic              busy,
  pcm_access_sched_if.master pcm
);

  localparam int               MAX_LAT   = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int               LAT_W     = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] RD_LOAD   = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD   = LAT_W'(WR_LAT - 1);
  localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT, DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [2:0]        retry_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              lat_done;
  logic              verify_ok;
  logic              can_retry;
  logic              req_c;
  logic              we_c;

  assign lat_done  = (lat_cnt == '0);
  assign verify_ok = (pcm.pcm_rdata == wdata_q);
  assign can_retry = (retry_cnt < RETRY_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    case (state)
      IDLE:    if (schedule) next_state = cpu_write ? WR_REQ : RD_REQ;
      RD_REQ: begin
        req_c = 1'b1;
        if (pcm.pcm_gnt) next_state = RD_WAIT;
      end
      RD_WAIT: if (lat_done) next_state = DONE;
      WR_REQ: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        if (pcm.pcm_gnt) next_state = WR_WAIT;
      end
      WR_WAIT: if (lat_done) next_state = VF_REQ;
      VF_REQ: begin
        req_c = 1'b1;
        if (pcm.pcm_gnt) next_state = VF_WAIT;
      end
      VF_WAIT: begin
        if (lat_done) begin
          if (verify_ok)      next_state = DONE;
          else if (can_retry) next_state = WR_REQ;
          else                next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The latched copy of the request drives the whole access, retries included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt   <= '0;
      retry_cnt <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_in   <= '0;
      wr_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (schedule) begin
            addr_q    <= addr;
            wdata_q   <= cpu_in;
            retry_cnt <= '0;
          end
        end
        RD_REQ, VF_REQ: if (pcm.pcm_gnt) lat_cnt <= RD_LOAD;
        WR_REQ:         if (pcm.pcm_gnt) lat_cnt <= WR_LOAD;
        RD_WAIT: begin
          if (lat_done) data_in <= pcm.pcm_rdata;
          else          lat_cnt <= lat_cnt - 1'b1;
        end
        WR_WAIT: if (!lat_done) lat_cnt <= lat_cnt - 1'b1;
        VF_WAIT: begin
          if (!lat_done) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else if (verify_ok) begin
            data_in <= wdata_q;
          end else if (can_retry) begin
            retry_cnt <= retry_cnt + 3'd1;
          end else begin
            wr_err  <= 1'b1;
            data_in <= pcm.pcm_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign resolved      = (state == DONE);
  assign busy          = (state != IDLE);
  assign pcm.pcm_req   = req_c;
  assign pcm.pcm_we    = we_c;
  assign pcm.pcm_addr  = addr_q;
  assign pcm.pcm_wdata = wdata_q;

endmodule

// File: tb/tb_pcm_access_sched.sv
// Bench for pcm_access_sched: a reactive PCM array plus a per-cycle timeline
// of every access built from request stalls and fixed array latencies.
module tb_pcm_access_sched;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 4;
  localparam int WR_LAT    = 12;
  localparam int MAX_RETRY = 3;
  localparam int N         = 16384;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              schedule;
  logic [ADDR_W-1:0] addr;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_in;
  logic              resolved;
  logic [DATA_W-1:0] data_in;
  logic              wr_err;
  logic              busy;

  pcm_access_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pcm ();

  pcm_access_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .schedule(schedule),
    .addr(addr),
    .cpu_write(cpu_write),
    .cpu_in(cpu_in),
    .resolved(resolved),
    .data_in(data_in),
    .wr_err(wr_err),
    .busy(busy),
    .pcm(pcm)
  );

  always #5 clk = ~clk;

  // Expected value of every observable output, indexed by cycle number.
  bit              exp_busy [N];
  bit              exp_req  [N];
  bit              exp_we   [N];
  bit              exp_res  [N];
  bit              exp_err  [N];
  bit [ADDR_W-1:0] exp_addr [N];
  bit [DATA_W-1:0] exp_wdata[N];
  bit [DATA_W-1:0] exp_data [N];

  int total;
  int bad;
  int cyc;
  int idle_from;
  int last_res;
  int prog_cnt;
  int acc;
  bit              model_err;
  bit [DATA_W-1:0] model_data;

  int              stall_q[$];
  bit [DATA_W-1:0] resp_q[$];
  int              cur_stall;
  int              pend_cycle;
  bit [DATA_W-1:0] pend_val;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic check_output();
    check_val("resolved",  32'(resolved),      32'(exp_res[cyc]));
    check_val("busy",      32'(busy),          32'(exp_busy[cyc]));
    check_val("pcm_req",   32'(pcm.pcm_req),   32'(exp_req[cyc]));
    check_val("pcm_we",    32'(pcm.pcm_we),    32'(exp_we[cyc]));
    check_val("pcm_addr",  32'(pcm.pcm_addr),  32'(exp_addr[cyc]));
    check_val("pcm_wdata", 32'(pcm.pcm_wdata), 32'(exp_wdata[cyc]));
    check_val("data_in",   32'(data_in),       32'(exp_data[cyc]));
    check_val("wr_err",    32'(wr_err),        32'(exp_err[cyc]));
    if (resolved === 1'b1) last_res = cyc;
  endtask

  // Array side: grants after the planned stall, returns read data RD_LAT later.
  task automatic slave_step();
    pcm.pcm_gnt   = 1'b0;
    pcm.pcm_rdata = DATA_W'($urandom);
    if (pend_cycle == cyc) pcm.pcm_rdata = pend_val;
    if (pcm.pcm_req === 1'b1) begin
      if (cur_stall < 0) cur_stall = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      if (cur_stall > 0) begin
        cur_stall--;
      end else begin
        pcm.pcm_gnt = 1'b1;
        cur_stall   = -1;
        if (pcm.pcm_we === 1'b1) begin
          prog_cnt++;
        end else begin
          pend_val   = (resp_q.size() > 0) ? resp_q.pop_front() : DATA_W'($urandom);
          pend_cycle = cyc + RD_LAT;
        end
      end
    end else begin
      pcm.pcm_gnt = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc >= N - 250) begin
      bad++;
      $display("[TB] FAIL cycle_budget got=%0d want<%0d", cyc, N - 250);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    check_output();
    slave_step();
  endtask

  // Plans one access, fills the expected timeline, then clocks through it.
  task automatic apply_stimulus(
    input  bit              wr,
    input  bit [ADDR_W-1:0] a,
    input  bit [DATA_W-1:0] d,
    input  bit [DATA_W-1:0] rv,
    input  int              n_bad,
    input  bit [DATA_W-1:0] bad_xor,
    input  int              stall_first,
    input  bit              rand_stall,
    input  int              abort_after,
    output int              accept
  );
    int              t;
    int              a_cyc;
    int              done;
    int              n_req;
    int              progs;
    int              s;
    int              stop;
    bit              is_prog;
    bit              fail;
    bit [DATA_W-1:0] bad_v;
    bit [DATA_W-1:0] fin;

    accept = (cyc > idle_from) ? cyc : idle_from;
    a_cyc  = accept + 1;
    progs  = (n_bad > MAX_RETRY) ? MAX_RETRY + 1 : n_bad + 1;
    fail   = wr && (n_bad > MAX_RETRY);
    n_req  = wr ? 2 * progs : 1;
    fin    = rv;
    t      = a_cyc;
    prog_cnt = 0;

    for (int i = 0; i < n_req; i++) begin
      is_prog = wr && (i % 2 == 0);
      s = rand_stall ? int'($urandom_range(0, 3)) : ((i == 0) ? stall_first : 0);
      stall_q.push_back(s);
      for (int k = t; k <= t + s && k < N; k++) begin
        exp_req[k] = 1'b1;
        exp_we[k]  = is_prog;
      end
      if (!wr) begin
        resp_q.push_back(rv);
      end else if (!is_prog) begin
        if (i / 2 < n_bad) begin
          bad_v = (bad_xor != '0) ? (d ^ bad_xor) : (d ^ DATA_W'($urandom_range(1, 65535)));
          resp_q.push_back(bad_v);
          fin = bad_v;
        end else begin
          resp_q.push_back(d);
          fin = d;
        end
      end
      t = t + s + (is_prog ? WR_LAT : RD_LAT) + 1;
    end
    done = t;

    for (int k = a_cyc; k <= done + 16 && k < N; k++) begin
      exp_busy[k]  = (k <= done);
      exp_res[k]   = (k == done);
      exp_addr[k]  = a;
      exp_wdata[k] = d;
      exp_data[k]  = (k < done) ? model_data : fin;
      exp_err[k]   = (k < done) ? model_err : (model_err | fail);
    end
    model_data = fin;
    model_err  = model_err | fail;
    idle_from  = done + 1;

    schedule  = 1'b1;
    addr      = a;
    cpu_in    = d;
    cpu_write = wr;
    while (cyc < accept) tick();

    stop = (abort_after >= 0) ? a_cyc + abort_after : done;
    while (cyc < stop) begin
      tick();
      schedule  = ($urandom_range(0, 1) == 1);
      addr      = ADDR_W'($urandom);
      cpu_in    = DATA_W'($urandom);
      cpu_write = ($urandom_range(0, 1) == 1);
    end
    schedule = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    schedule = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserts reset mid-cycle so the abandoned access must vanish immediately.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_n  = 1'b0;
    schedule = 1'b0;
    for (int k = cyc + 1; k <= cyc + 200 && k < N; k++) begin
      exp_busy[k]  = 1'b0;
      exp_req[k]   = 1'b0;
      exp_we[k]    = 1'b0;
      exp_res[k]   = 1'b0;
      exp_err[k]   = 1'b0;
      exp_addr[k]  = '0;
      exp_wdata[k] = '0;
      exp_data[k]  = '0;
    end
    model_data = '0;
    model_err  = 1'b0;
    stall_q.delete();
    resp_q.delete();
    cur_stall  = -1;
    pend_cycle = -1;
    tick();
    check_val("rst_busy_now", 32'(busy), 32'd0);
    check_val("rst_req_now",  32'(pcm.pcm_req), 32'd0);
    tick();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    idle_from = cyc;
  endtask

  initial begin
    int n_bad;
    int gap;
    bit wr;

    total = 0;  bad = 0;  cyc = 0;  idle_from = 0;  last_res = -1;  prog_cnt = 0;
    model_err = 1'b0;  model_data = '0;
    cur_stall = -1;  pend_cycle = -1;  pend_val = '0;
    reset_n = 1'b0;  schedule = 1'b0;  addr = '0;  cpu_write = 1'b0;  cpu_in = '0;
    pcm.pcm_gnt = 1'b0;  pcm.pcm_rdata = '0;

    tick();
    tick();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    idle_from = cyc;

    $display("[TB] read");
    apply_stimulus(1'b0, 20'h0ABCD, 16'h5555, 16'h1234, 0, 16'h0, 0, 1'b0, -1, acc);
    check_val("t1_latency", 32'(last_res - acc), 32'd6);
    check_val("t1_data", 32'(data_in), 32'h1234);
    check_val("t1_programs", 32'(prog_cnt), 32'd0);

    $display("[TB] clean write");
    apply_stimulus(1'b1, 20'h12345, 16'hBEEF, 16'h0, 0, 16'h0, 0, 1'b0, -1, acc);
    check_val("t2_latency", 32'(last_res - acc), 32'd19);
    check_val("t2_err", 32'(wr_err), 32'd0);
    check_val("t2_programs", 32'(prog_cnt), 32'd1);
    check_val("t2_data", 32'(data_in), 32'hBEEF);

    $display("[TB] write with two retries");
    apply_stimulus(1'b1, 20'h00F0F, 16'hBEEF, 16'h0, 2, 16'hBEEF, 0, 1'b0, -1, acc);
    check_val("t3_programs", 32'(prog_cnt), 32'd3);
    check_val("t3_err", 32'(wr_err), 32'd0);
    check_val("t3_data", 32'(data_in), 32'hBEEF);
    check_val("t3_latency", 32'(last_res - acc), 32'd55);

    $display("[TB] write failing verify");
    apply_stimulus(1'b1, 20'hFFFFF, 16'hA5A5, 16'h0, 4, 16'hFFFF, 0, 1'b0, -1, acc);
    check_val("t4_programs", 32'(prog_cnt), 32'd4);
    check_val("t4_err", 32'(wr_err), 32'd1);
    check_val("t4_data", 32'(data_in), 32'h5A5A);
    check_val("t4_latency", 32'(last_res - acc), 32'd73);
    idle_gap(2);
    apply_stimulus(1'b0, 20'h00001, 16'h0000, 16'h0F0F, 0, 16'h0, 0, 1'b0, -1, acc);
    check_val("t4_sticky", 32'(wr_err), 32'd1);

    $display("[TB] grant stall");
    apply_stimulus(1'b0, 20'h54321, 16'h1111, 16'hC3C3, 0, 16'h0, 5, 1'b0, -1, acc);
    check_val("t5_latency", 32'(last_res - acc), 32'd11);
    check_val("t5_data", 32'(data_in), 32'hC3C3);

    $display("[TB] reset during write wait");
    apply_stimulus(1'b1, 20'h0AAAA, 16'h7777, 16'h0, 0, 16'h0, 0, 1'b0, 3, acc);
    apply_reset();
    check_val("t6_err_cleared", 32'(wr_err), 32'd0);
    apply_stimulus(1'b0, 20'h0BBBB, 16'h0000, 16'h2468, 0, 16'h0, 0, 1'b0, -1, acc);
    check_val("t6_latency", 32'(last_res - acc), 32'd6);
    check_val("t6_data", 32'(data_in), 32'h2468);

    $display("[TB] random accesses");
    for (int it = 0; it < 150 && cyc < N - 600; it++) begin
      wr    = ($urandom_range(0, 1) == 1);
      n_bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAX_RETRY + 1)) : 0;
      apply_stimulus(wr, ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                     n_bad, 16'h0, 0, 1'b1, -1, acc);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle_gap(gap);
    end
    idle_gap(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
